// File: rtl/alb_mss_mem_lat_dly_line_if.sv
// Sample, config and status bundle for the MSS latency delay line.
// master drives samples and cfg_delay; slave is the delay line.
interface alb_mss_mem_lat_dly_line_if #(
    parameter int WIDTH = 2,
    parameter int AW    = 10
);
    logic [AW:0]      cfg_delay;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             busy;

    modport master (
        output cfg_delay,
        output in_valid,
        output in_data,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  busy
    );

    modport slave (
        input  cfg_delay,
        input  in_valid,
        input  in_data,
        output in_ready,
        output out_valid,
        output out_data,
        output busy
    );
endinterface

// File: rtl/alb_mss_mem_lat_dly_line.sv
// Programmable-latency delay line on one 1W/1R RAM with a circular pointer.
// Define ALB_MSS_DLY_STATS_EN to add the stat_inflight/stat_drop counters.
module alb_mss_mem_lat_dly_line #(
    parameter int WIDTH   = 2,
    parameter int DEPTH   = 1024,
    parameter int AW      = 10,
    parameter int MIN_DLY = 2
) (
    input  logic clk,
    input  logic rst_a,
    alb_mss_mem_lat_dly_line_if.slave bus
`ifdef ALB_MSS_DLY_STATS_EN
    ,
    output logic [AW:0] stat_inflight,
    output logic [15:0] stat_drop
`endif
);

    typedef enum logic [1:0] {
        CLEAR,
        FILL,
        RUN
    } state_t;

    localparam int RW = WIDTH + 1;

    localparam logic [AW:0] DLY_MIN = (AW+1)'(MIN_DLY);
    localparam logic [AW:0] DLY_MAX = (AW+1)'(DEPTH);
    localparam logic [AW:0] DLY_ONE = (AW+1)'(1);

    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW-1:0] PTR_TWO  = AW'(2);

    state_t state_q;
    state_t state_d;

    logic [AW-1:0] wptr_q;
    logic [AW-1:0] clr_ptr_q;
    logic [AW-1:0] waddr;
    logic [AW-1:0] raddr;
    logic [AW-1:0] raddr_q;

    logic [AW:0] dly_q;
    logic [AW:0] dly_d;
    logic [AW:0] dly_cfg;
    logic [AW:0] fill_cnt_q;
    logic [AW:0] fill_cnt_d;

    logic [RW-1:0] mem [DEPTH];
    logic [RW-1:0] wdata;
    logic [RW-1:0] rdata;

    logic             dly_chg;
    logic             run_pass;
    logic             rd_hit;
    logic             ready;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;

    always_comb begin
        dly_cfg = bus.cfg_delay;
        if (bus.cfg_delay < DLY_MIN) begin
            dly_cfg = DLY_MIN;
        end else if (bus.cfg_delay > DLY_MAX) begin
            dly_cfg = DLY_MAX;
        end
    end

    assign ready   = (state_q != CLEAR);
    assign dly_chg = ready && (dly_cfg != dly_q);

    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            state_q    <= CLEAR;
            dly_q      <= DLY_MIN;
            fill_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            dly_q      <= dly_d;
            fill_cnt_q <= fill_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        dly_d      = dly_q;
        fill_cnt_d = fill_cnt_q;
        unique case (state_q)
            CLEAR: begin
                if (clr_ptr_q == PTR_LAST) begin
                    state_d = RUN;
                    dly_d   = dly_cfg;
                end
            end
            FILL, RUN: begin
                if (dly_chg) begin
                    state_d    = FILL;
                    dly_d      = dly_cfg;
                    fill_cnt_d = dly_cfg - DLY_ONE;
                end else if (state_q == FILL) begin
                    fill_cnt_d = fill_cnt_q - DLY_ONE;
                    if (fill_cnt_q == DLY_ONE) begin
                        state_d = RUN;
                    end
                end
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            wptr_q    <= '0;
            clr_ptr_q <= '0;
        end else if (state_q == CLEAR) begin
            clr_ptr_q <= clr_ptr_q + PTR_ONE;
        end else begin
            wptr_q <= wptr_q + PTR_ONE;
        end
    end

    always_comb begin
        if (state_q == CLEAR) begin
            waddr = clr_ptr_q;
            wdata = '0;
        end else begin
            waddr = wptr_q;
            wdata = {bus.in_valid, bus.in_data};
        end
    end

    // (wptr+1) - dly + 1: uses the delay taking effect next, so a new
    // delay of MIN_DLY already reads the sample accepted this cycle.
    assign raddr = wptr_q + PTR_TWO - dly_d[AW-1:0];

    always_ff @(posedge clk) begin
        mem[waddr] <= wdata;
        raddr_q    <= raddr;
    end

    assign rdata = mem[raddr_q];

    // Reads issued before CLEAR completes may see uncleared words.
    assign run_pass = ready && (state_d == RUN);
    assign rd_hit   = run_pass && rdata[RW-1];

    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= rd_hit;
            out_data_q  <= rd_hit ? rdata[WIDTH-1:0] : '0;
        end
    end

    assign bus.in_ready  = ready;
    assign bus.busy      = (state_q != RUN);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

`ifdef ALB_MSS_DLY_STATS_EN
    logic        accept;
    logic [16:0] drop_sum;

    assign accept   = ready && bus.in_valid;
    assign drop_sum = {1'b0, stat_drop} + 17'(stat_inflight);

    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            stat_inflight <= '0;
            stat_drop     <= '0;
        end else if (!ready) begin
            stat_inflight <= '0;
            stat_drop     <= '0;
        end else if (dly_chg) begin
            stat_inflight <= (AW+1)'(accept);
            stat_drop     <= drop_sum[16] ? 16'hffff : drop_sum[15:0];
        end else begin
            stat_inflight <= stat_inflight
                           + (AW+1)'(accept)
                           - (AW+1)'(out_valid_q);
        end
    end
`endif

endmodule

// File: tb/tb_alb_mss_mem_lat_dly_line.sv
// Randomised scoreboard bench for the MSS latency delay line.
module tb_alb_mss_mem_lat_dly_line;

    localparam int WIDTH   = 8;
    localparam int DEPTH   = 1024;
    localparam int AW      = 10;
    localparam int MIN_DLY = 2;

    typedef struct {
        int               due;
        logic [WIDTH-1:0] data;
    } smp_t;

    typedef struct {
        logic rdy;
        logic bsy;
        int   infl;
        int   drop;
    } st_t;

    logic clk   = 1'b0;
    logic rst_a = 1'b1;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    smp_t exp_q[$];
    st_t  st_q[$];

    int dly_m      = MIN_DLY;
    int clear_left = 0;
    int fill_end   = 0;
    int infl_m     = 0;
    int drop_m     = 0;
    int cfg        = 6;

    alb_mss_mem_lat_dly_line_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

`ifdef ALB_MSS_DLY_STATS_EN
    logic [AW:0] stat_inflight;
    logic [15:0] stat_drop;
`endif

    alb_mss_mem_lat_dly_line #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .AW     (AW),
        .MIN_DLY(MIN_DLY)
    ) dut (
        .clk  (clk),
        .rst_a(rst_a),
        .bus  (bus)
`ifdef ALB_MSS_DLY_STATS_EN
        ,
        .stat_inflight(stat_inflight),
        .stat_drop    (stat_drop)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int clamp(input int c);
        if (c < MIN_DLY) return MIN_DLY;
        if (c > DEPTH) return DEPTH;
        return c;
    endfunction

    function automatic void check(input string name,
                                  input longint act,
                                  input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d",
                     name, cyc, act, exp);
        end
    endfunction

    task automatic do_reset();
        rst_a = 1'b1;
        exp_q.delete();
        infl_m = 0;
        drop_m = 0;
        st_q.push_back('{1'b0, 1'b1, 0, 0});
        @(posedge clk);
        #1;
        rst_a      = 1'b0;
        clear_left = DEPTH;
    endtask

    // One cycle of stimulus plus the reference model's view of that cycle.
    task automatic step(input logic v,
                        input logic [WIDTH-1:0] d,
                        input int c);
        int   dn;
        logic ov;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.cfg_delay = (AW+1)'(c);
        ov = (exp_q.size() > 0) && (exp_q[0].due == cyc);
        if (clear_left > 0) begin
            st_q.push_back('{1'b0, 1'b1, 0, 0});
            if (clear_left == 1) begin
                dly_m    = clamp(c);
                fill_end = 0;
            end
            clear_left--;
        end else begin
            dn = clamp(c);
            st_q.push_back('{1'b1, logic'(cyc < fill_end), infl_m, drop_m});
            if (dn != dly_m) begin
                while (exp_q.size() > 0 && exp_q[$].due > cyc)
                    void'(exp_q.pop_back());
                dly_m    = dn;
                fill_end = cyc + dn;
                drop_m   = (drop_m + infl_m > 65535) ? 65535 : drop_m + infl_m;
                infl_m   = int'(v);
            end else begin
                infl_m = infl_m + int'(v) - int'(ov);
            end
            if (v) exp_q.push_back('{cyc + dly_m, d});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        st_t  s;
        smp_t e;
        forever begin
            @(negedge clk);
            if (st_q.size() > 0) begin
                s = st_q.pop_front();
                check("in_ready", bus.in_ready, s.rdy);
                check("busy", bus.busy, s.bsy);
`ifdef ALB_MSS_DLY_STATS_EN
                check("stat_inflight", stat_inflight, s.infl);
                check("stat_drop", stat_drop, s.drop);
`endif
                if (bus.out_valid) begin
                    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                        e = exp_q.pop_front();
                        check("out_data", bus.out_data, e.data);
                    end else begin
                        check("out_valid_unexpected", 1, 0);
                    end
                end else begin
                    check("bubble_data", bus.out_data, 0);
                    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                        void'(exp_q.pop_front());
                        check("out_valid_missing", 0, 1);
                    end
                end
            end
        end
    end

    initial begin
        bus.cfg_delay = 11'd5;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        @(posedge clk);
        #1;
        do_reset();
        for (int i = 0; i < DEPTH; i++)
            step(1'($urandom_range(0, 1)), WIDTH'($urandom), 5);
        for (int i = 1; i <= 40; i++)
            step(1'b1, WIDTH'(i), 5);
        for (int i = 0; i < 60; i++)
            step(1'b1, WIDTH'(i), 0);
        for (int i = 0; i < 2100; i++)
            step(1'b1, WIDTH'(i), 2000);
        for (int i = 0; i < 20; i++)
            step(1'b1, WIDTH'(i + 100), 8);
        for (int i = 0; i < 15; i++)
            step(1'b1, WIDTH'(i + 200), 3);
        for (int i = 0; i < 30; i++)
            step(1'(i % 2 == 0), WIDTH'(i + 1), 4);
        cfg = 6;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 39) == 0) cfg = $urandom_range(0, 24);
            if ($urandom_range(0, 299) == 0) cfg = $urandom_range(1000, 2047);
            step(1'($urandom_range(0, 3) != 0), WIDTH'($urandom), cfg);
        end
        for (int i = 0; i < 30; i++)
            step(1'b1, WIDTH'($urandom), 6);
        do_reset();
        for (int i = 0; i < DEPTH; i++)
            step(1'b1, WIDTH'($urandom), 7);
        for (int i = 0; i < 40; i++)
            step(1'($urandom_range(0, 1)), WIDTH'($urandom), 7);
        for (int i = 0; i < DEPTH + 10; i++)
            step(1'b0, '0, 7);
        @(negedge clk);
        #1;
        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
